// File: rtl/pe_loader.sv
// rtl/pe_loader.sv - host-stream loader: instruction pass-through, then buffered data bursts to the PE
// Optional feature macro: LOADER_LAST_CHK_EN (s_last framing check driving the sticky err flag).
module pe_loader #(
    parameter int INST_NUM   = 32,
    parameter int LOAD_NUM   = 16,
    parameter int ITER_NUM   = 4,
    parameter int GAP_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        inst_out_v,
    output logic [31:0] inst_out,
    output logic        din_pe_v,
    output logic [31:0] din_pe,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int IW = (INST_NUM > 1) ? $clog2(INST_NUM) : 1;
    localparam int AW = (LOAD_NUM > 1) ? $clog2(LOAD_NUM) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 2);

    localparam logic [IW-1:0] INST_LAST = IW'(INST_NUM - 1);
    localparam logic [AW-1:0] LOAD_LAST = AW'(LOAD_NUM - 1);
    localparam logic [6:0]    ITER_LAST = 7'(ITER_NUM - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        INST,
        FILL,
        BURST,
        WAIT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   inst_cnt_q, inst_cnt_d;
    logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [6:0]      iter_q, iter_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            err_q, err_d;
    logic            inst_out_v_q;
    logic [31:0]     inst_out_q;
    logic            din_pe_v_q;
    logic [31:0]     din_pe_q;
    logic [31:0]     mem_q [LOAD_NUM];
    logic            accept;
    logic            last_bad;

    // s_ready depends only on the registered state, never on s_valid
    assign s_ready    = (state_q == INST) || (state_q == FILL);
    assign accept     = s_valid && s_ready;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign inst_out_v = inst_out_v_q;
    assign inst_out   = inst_out_q;
    assign din_pe_v   = din_pe_v_q;
    assign din_pe     = din_pe_q;

`ifndef LOADER_LAST_CHK_EN
    logic unused_s_last;
    assign unused_s_last = s_last;
`endif

    // framing check: s_last must mark exactly the final word of each block
    always_comb begin
        last_bad = 1'b0;
`ifdef LOADER_LAST_CHK_EN
        if (state_q == INST) begin
            last_bad = (s_last != (inst_cnt_q == INST_LAST));
        end else if (state_q == FILL) begin
            last_bad = (s_last != (wr_cnt_q == LOAD_LAST));
        end
`endif
    end

    // next-state and counter updates
    always_comb begin
        state_d    = state_q;
        inst_cnt_d = inst_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        iter_d     = iter_q;
        gap_d      = gap_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = INST;
                    inst_cnt_d = '0;
                    wr_cnt_d   = '0;
                    rd_cnt_d   = '0;
                    iter_d     = '0;
                    gap_d      = '0;
                    err_d      = 1'b0;
                end
            end
            INST: begin
                if (accept) begin
                    if (last_bad) begin
                        err_d      = 1'b1;
                        inst_cnt_d = '0;
                        state_d    = IDLE;
                    end else if (inst_cnt_q == INST_LAST) begin
                        inst_cnt_d = '0;
                        state_d    = FILL;
                    end else begin
                        inst_cnt_d = inst_cnt_q + 1'b1;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    if (last_bad) begin
                        // abandon the partially filled buffer; no burst is driven
                        err_d    = 1'b1;
                        wr_cnt_d = '0;
                        iter_d   = '0;
                        state_d  = IDLE;
                    end else if (wr_cnt_q == LOAD_LAST) begin
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        state_d  = BURST;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            BURST: begin
                if (rd_cnt_q == LOAD_LAST) begin
                    rd_cnt_d = '0;
                    iter_d   = iter_q + 7'd1;
                    gap_d    = '0;
                    if (iter_q == ITER_LAST) begin
                        state_d = DONE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = FILL;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            WAIT: begin
                // first WAIT cycle overlaps the final din_pe_v beat, so count 0..GAP_CYCLES
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = FILL;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            DONE: begin
                iter_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, counters and registered output streams
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            inst_cnt_q   <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            iter_q       <= '0;
            gap_q        <= '0;
            err_q        <= 1'b0;
            inst_out_v_q <= 1'b0;
            inst_out_q   <= '0;
            din_pe_v_q   <= 1'b0;
            din_pe_q     <= '0;
        end else begin
            state_q      <= state_d;
            inst_cnt_q   <= inst_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            iter_q       <= iter_d;
            gap_q        <= gap_d;
            err_q        <= err_d;
            inst_out_v_q <= (state_q == INST) && s_valid;
            inst_out_q   <= ((state_q == INST) && s_valid) ? s_data : 32'd0;
            din_pe_v_q   <= (state_q == BURST);
            din_pe_q     <= (state_q == BURST) ? mem_q[rd_cnt_q] : 32'd0;
        end
    end

    // burst buffer storage; contents are only meaningful once a fill completes
    always_ff @(posedge clk) begin
        if ((state_q == FILL) && accept) begin
            mem_q[wr_cnt_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_pe_loader.sv
// tb/tb_pe_loader.sv - scoreboard bench for pe_loader (dut_a: 2 bursts with gap 3, dut_b: 1 burst, gap 0)
module tb_pe_loader;

    localparam int IN = 4;
    localparam int LN = 4;
`ifdef LOADER_LAST_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic [1:0]  rst, start, s_valid, s_last, s_ready, inst_out_v, din_pe_v, busy, done, err;
    logic [31:0] s_data [2];
    logic [31:0] inst_out [2];
    logic [31:0] din_pe [2];

    always #5 clk = ~clk;

    pe_loader #(.INST_NUM(IN), .LOAD_NUM(LN), .ITER_NUM(2), .GAP_CYCLES(3)) dut_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data[0]), .s_last(s_last[0]), .inst_out_v(inst_out_v[0]), .inst_out(inst_out[0]),
        .din_pe_v(din_pe_v[0]), .din_pe(din_pe[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    pe_loader #(.INST_NUM(IN), .LOAD_NUM(LN), .ITER_NUM(1), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data[1]), .s_last(s_last[1]), .inst_out_v(inst_out_v[1]), .inst_out(inst_out[1]),
        .din_pe_v(din_pe_v[1]), .din_pe(din_pe[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } item_t;

    typedef struct {
        int          dut;
        logic [31:0] ibase;
        logic [31:0] dbase;
        logic [3:0]  stall;
        int          last_pos;
        bit          start_in_burst;
        bit          exp_err;
    } vec_t;

    item_t inst_q [2][$];
    item_t data_q [2][$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    done_cnt [2];
    int    done_cyc [2];
    int    din_cnt [2];
    int    iters_of [2];
    int    gap_of [2];
    bit    mon_en = 1'b0;
    vec_t  tbl [6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // output monitor: pops expected words and checks value and arrival cycle
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                item_t it;
                if (inst_out_v[i]) begin
                    chk("inst_expected", 32'(inst_q[i].size() > 0), 1);
                    if (inst_q[i].size() > 0) begin
                        it = inst_q[i].pop_front();
                        chk("inst_data", inst_out[i], it.data);
                        chk("inst_cycle", cyc, it.cyc);
                    end
                end else begin
                    chk("inst_zero", inst_out[i], 0);
                end
                if (din_pe_v[i]) begin
                    din_cnt[i]++;
                    chk("din_expected", 32'(data_q[i].size() > 0), 1);
                    if (data_q[i].size() > 0) begin
                        it = data_q[i].pop_front();
                        chk("din_data", din_pe[i], it.data);
                        chk("din_cycle", cyc, it.cyc);
                    end
                end else begin
                    chk("din_zero", din_pe[i], 0);
                end
                if (done[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                end
            end
        end
    end

    task automatic send(input int d, input int n, input logic [31:0] base, input logic [3:0] stall,
                        input int last_pos, input bit is_data, input bit push,
                        output int first_c, output int last_c);
        logic [31:0] words [$];
        int c;
        first_c = -1;
        last_c  = -1;
        for (int k = 0; k < n; k++) begin
            if (stall[k]) begin
                s_valid[d] = 1'b0;
                @(posedge clk); #1;
            end
            s_valid[d] = 1'b1;
            s_data[d]  = base + 32'(k);
            s_last[d]  = (k == last_pos);
            c = -1;
            for (int w = 0; w < 100 && c < 0; w++) begin
                @(negedge clk);
                if (s_ready[d]) c = cyc;
            end
            chk("accepted", 32'(c >= 0), 1);
            if (c < 0) begin
                s_valid[d] = 1'b0;
                s_last[d]  = 1'b0;
                return;
            end
            if (k == 0) first_c = c;
            last_c = c;
            if (!is_data) inst_q[d].push_back('{base + 32'(k), c + 1});
            else words.push_back(base + 32'(k));
            @(posedge clk); #1;
        end
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
        s_data[d]  = 32'd0;
        if (is_data && push) begin
            for (int k = 0; k < n; k++) data_q[d].push_back('{words[k], last_c + 2 + k});
        end
    endtask

    task automatic run(input vec_t v);
        int d, fc, lc, prev_lc, dn0, din0;
        d    = v.dut;
        dn0  = done_cnt[d];
        din0 = din_cnt[d];
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        send(d, IN, v.ibase, 4'b0000, IN - 1, 1'b0, 1'b0, fc, lc);
        chk("err_clear_after_start", 32'(err[d]), 0);
        if (v.exp_err) begin
            send(d, v.last_pos + 1, v.dbase, v.stall, v.last_pos, 1'b1, 1'b0, fc, lc);
            repeat (6) @(negedge clk);
            chk("err_set", 32'(err[d]), 1);
            chk("err_busy", 32'(busy[d]), 0);
            chk("err_no_burst", din_cnt[d] - din0, 0);
            chk("err_no_done", done_cnt[d] - dn0, 0);
            return;
        end
        prev_lc = -1;
        for (int it = 0; it < iters_of[d]; it++) begin
            send(d, LN, v.dbase + 32'(16 * it), (it == 0) ? v.stall : 4'b0000,
                 (it == 0) ? v.last_pos : LN - 1, 1'b1, 1'b1, fc, lc);
            if (it > 0) begin
                chk("gap_reopen_cycle", fc, (gap_of[d] == 0) ? prev_lc + LN + 1 : prev_lc + LN + 2 + gap_of[d]);
            end
            if (it == 0 && v.start_in_burst) begin
                start[d] = 1'b1;
                @(posedge clk); #1;
                start[d] = 1'b0;
            end
            prev_lc = lc;
        end
        for (int w = 0; w < 200 && done_cnt[d] == dn0; w++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt[d] - dn0, 1);
        chk("done_cycle", done_cyc[d], prev_lc + LN + 1);
        chk("busy_after_done", 32'(busy[d]), 0);
        chk("burst_words", din_cnt[d] - din0, LN * iters_of[d]);
        chk("err_normal", 32'(err[d]), 0);
        chk("queues_drained", inst_q[d].size() + data_q[d].size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int fc, lc;
        iters_of[0] = 2; gap_of[0] = 3;
        iters_of[1] = 1; gap_of[1] = 0;
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0; done_cyc[i] = 0; din_cnt[i] = 0; s_data[i] = 32'd0;
        end
        tbl[0] = '{0, 32'h1000_0000, 32'hA000_0001, 4'b0000, 3, 1'b0, 1'b0};
        tbl[1] = '{0, 32'h1100_0000, 32'hA000_0001, 4'b1110, 3, 1'b0, 1'b0};
        tbl[2] = '{1, 32'h2000_0000, 32'hB000_0000, 4'b0101, 3, 1'b1, 1'b0};
        tbl[3] = '{0, 32'h3000_0000, 32'hC000_0000, 4'b0000, 2, 1'b0, CHK};
        tbl[4] = '{0, 32'h4000_0000, 32'hD000_0000, 4'b0000, 3, 1'b0, 1'b0};
        tbl[5] = '{1, 32'h5000_0000, 32'hE000_0000, 4'b0010, 1, 1'b0, CHK};

        // reset, with start held high while reset is asserted
        rst = 2'b11; start = 2'b00; s_valid = 2'b00; s_last = 2'b00;
        repeat (2) begin @(posedge clk); #1; end
        start = 2'b11;
        @(posedge clk); #1;
        start = 2'b00;
        rst = 2'b00;
        @(negedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_s_ready", 32'(s_ready[i]), 0);
            chk("rst_inst_v", 32'(inst_out_v[i]), 0);
            chk("rst_din_v", 32'(din_pe_v[i]), 0);
            chk("rst_done", 32'(done[i]), 0);
            chk("rst_err", 32'(err[i]), 0);
        end

        for (int t = 0; t < 6; t++) run(tbl[t]);

        // reset on the second burst beat of dut_a
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        send(0, IN, 32'h6000_0000, 4'b0000, IN - 1, 1'b0, 1'b0, fc, lc);
        send(0, LN, 32'h6600_0000, 4'b0000, LN - 1, 1'b1, 1'b1, fc, lc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[0] = 1'b1;
        @(negedge clk);
        chk("rst_mid_second_beat", 32'(din_pe_v[0]), 1);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid_din_v", 32'(din_pe_v[0]), 0);
        chk("rst_mid_busy", 32'(busy[0]), 0);
        chk("rst_mid_s_ready", 32'(s_ready[0]), 0);
        data_q[0].delete();
        repeat (2) @(negedge clk);
        run(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_loader.md
PE_LOADER -- requirements
Module: pe_loader

Interface
REQ-001 Parameter: INST_NUM, 32, instruction words per program.
REQ-002 Parameter: LOAD_NUM, 16, data words per iteration burst; range 1..64.
REQ-003 Parameter: ITER_NUM, 4, bursts per run; range 1..127.
REQ-004 Parameter: GAP_CYCLES, 48, idle cycles after each non-final burst (covers downstream compute/transmit); 0 is legal.
REQ-005 Port: clk  in  1  sole clock, rising edge.
REQ-006 Port: rst  in  1  reset, synchronous, active-high.
REQ-007 Port: start  in  1  one-cycle run request.
REQ-008 Port: s_valid / s_ready  in / out  1 / 1  host stream handshake; a word transfers when both are high.
REQ-009 Port: s_data  in  32  host word (instruction, or complex data word {re[15:0], im[15:0]}).
REQ-010 Port: s_last  in  1  end-of-block marker (used only with LOADER_LAST_CHK_EN).
REQ-011 Port: inst_out_v / inst_out  out  1 / 32  instruction stream to the PE instruction memory.
REQ-012 Port: din_pe_v / din_pe  out  1 / 32  data burst to the PE.
REQ-013 Port: busy / done / err  out  1 each  run active / one-cycle completion pulse / sticky error.

Function
REQ-014 The FSM SHALL have states IDLE, INST, FILL, BURST, WAIT, DONE.
REQ-015 IDLE→INST on start; start outside IDLE is ignored.
REQ-016 INST: s_ready=1; each accepted word appears on inst_out with inst_out_v=1 exactly one cycle later; after INST_NUM accepted words → FILL.
REQ-017 FILL: s_ready=1; accepted words are written in order into a LOAD_NUM-deep buffer; s_valid gaps only stall filling; after the LOAD_NUM-th word → BURST.
REQ-018 BURST: s_ready=0; if the last fill word is accepted in cycle t, din_pe_v SHALL be high for exactly LOAD_NUM consecutive cycles t+2..t+LOAD_NUM+1, with din_pe carrying the words in acceptance order.
REQ-019 After a burst, a 7-bit iteration counter increments; if it equals ITER_NUM → DONE, else → WAIT.
REQ-020 WAIT: s_ready=0 for GAP_CYCLES cycles following the last din_pe_v cycle, then → FILL; GAP_CYCLES=0 → FILL directly.
REQ-021 DONE: done=1 for exactly one cycle, then → IDLE; the iteration counter clears.
REQ-022 busy=1 in every state except IDLE.
REQ-023 s_ready SHALL be a registered-state decode (no combinational path from s_valid).
REQ-024 din_pe and inst_out SHALL be zero whenever their valid is low.

Reset
REQ-025 rst overrides every other input, including simultaneous start.
REQ-026 On rst: state=IDLE; all counters=0; s_ready, inst_out_v, din_pe_v, busy, done, err=0; inst_out, din_pe=0.
REQ-027 rst mid-burst SHALL drop din_pe_v the following cycle; buffered words are discarded.

Configuration
REQ-028 Macro LOADER_LAST_CHK_EN defined: in INST, s_last must be high on instruction word INST_NUM only; in FILL, on data word LOAD_NUM only. Any mismatch on an accepted word sets err, and the FSM goes to IDLE the next cycle without driving a burst. err clears only on rst or start.
REQ-029 Macro undefined: s_last is ignored, err is tied 0.

Verification
REQ-030 Nominal: INST_NUM=4, LOAD_NUM=4, ITER_NUM=2, GAP_CYCLES=3, s_valid always high. Expect 4 inst_out pulses, then 4-cycle din_pe_v, then 3 cycles s_ready=0, then a second 4-cycle burst, then a done pulse, then busy=0.
REQ-031 Stalled fill: s_valid toggles 1,0,1,0 during FILL. The burst is still 4 contiguous cycles, and data equals the accepted words 0xA0000001..0xA0000004 in order.
REQ-032 Boundary: ITER_NUM=1, GAP_CYCLES=0. Expect one burst, then DONE directly with no WAIT cycle. Also pulse start during BURST: it is ignored.
REQ-033 Reset mid-burst: assert rst on the 2nd din_pe_v cycle. Next cycle, din_pe_v=0, busy=0, s_ready=0. A subsequent start runs correctly from INST.
REQ-034 Last-check (LOADER_LAST_CHK_EN): raise s_last on data word 3 of 4. Expect err=1, no din_pe_v, return to IDLE. Build without the macro: same stimulus gives a normal burst and err=0.
